i2c_byte_master: RTL and testbench

- Single-byte I2C bus generator.
- Drives SCL/SDA to produce a START, 8 data bits MSB-first, an ACK slot and an optional STOP, each byte taken from a valid/ready input.
- Serves as the on-chip stimulus source for the analyzer's I2C capture path.
- Also drives external I2C targets through open-drain pads: a 1 on an output means release the line, 0 means drive it low.

---
 rtl/i2c_byte_master.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: single-byte I2C bus generator.
//
// Each byte taken from a valid/ready handshake is sent as a START (skipped
// when the bus is still owned from the previous byte), 8 data bits MSB
// first, an ACK slot and an optional STOP. scl_o/sda_o drive open-drain
// pads: 1 releases the line, 0 pulls it low.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   tx_valid  a byte is offered
//   tx_ready  the block can accept a byte (IDLE and HOLD only)
//   tx_data   byte to send, MSB first
//   tx_stop   issue STOP after this byte (latched with tx_data)
//   sda_i     synchronised SDA line level, sampled in the ACK slot
//   scl_o     SCL drive (1 = release)
//   sda_o     SDA drive (1 = release)
//   busy      high in every state except IDLE
//   ack_valid one-cycle pulse after the ACK slot has been sampled
//   ack_nack  last sampled ACK level (0 = ACK, 1 = NACK)
//
// DIV is the number of clocks per SCL quarter period and must be >= 1.

module i2c_byte_master #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_stop,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy,
  output logic       ack_valid,
  output logic       ack_nack
);

  localparam int              QW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0]   QMAX = QW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_HOLD
  } state_t;

  state_t        state;
  logic [QW-1:0] q;        // clocks within the current quarter
  logic [1:0]    phase;    // quarter within the current bit/slot
  logic [2:0]    bit_idx;  // data bit currently on SDA
  logic [7:0]    data;
  logic          stop;

  logic tick;
  logic accept;

  assign tick   = (q == QMAX);
  assign accept = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    // NOTE: state registers are written only with non-blocking assignments;
    // where a branch assigns a register twice, the later assignment wins,
    // which is used below to override the default counter/pulse updates.
    if (!rst_n) begin
      // NOTE: every register, including the data/stop latch, is reset so
      // nothing in the datapath powers up as X.
      state     <= S_IDLE;
      q         <= '0;
      phase     <= '0;
      bit_idx   <= '0;
      data      <= '0;
      stop      <= 1'b0;
      tx_ready  <= 1'b0;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
      busy      <= 1'b0;
      ack_valid <= 1'b0;
      ack_nack  <= 1'b0;
    end else begin
      ack_valid <= 1'b0;
      // Every state change happens on a tick, so wrapping q here also
      // clears it on state entry.
      q <= tick ? '0 : q + 1'b1;

      case (state)
        S_IDLE: begin
          q        <= '0;
          scl_o    <= 1'b1;
          sda_o    <= 1'b1;
          tx_ready <= 1'b1;
          if (accept) begin
            data     <= tx_data;
            stop     <= tx_stop;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            sda_o    <= 1'b0;        // START: SDA falls while SCL is high
            phase    <= '0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            phase <= phase + 2'd1;
            if (phase == 2'd1) begin
              phase   <= '0;
              bit_idx <= 3'd7;
              scl_o   <= 1'b0;
              sda_o   <= data[7];
              state   <= S_BIT;
            end
          end
        end

        S_BIT: begin
          if (tick) begin
            phase <= phase + 2'd1;   // wraps 3 -> 0 into the next bit
            case (phase)
              2'd1: scl_o <= 1'b1;
              2'd3: begin
                // SDA only moves together with the falling SCL edge.
                scl_o <= 1'b0;
                if (bit_idx == 3'd0) begin
                  sda_o <= 1'b1;     // release SDA for the target's ACK
                  state <= S_ACK;
                end else begin
                  bit_idx <= bit_idx - 3'd1;
                  sda_o   <= data[bit_idx - 3'd1];
                end
              end
              default: ;
            endcase
          end
        end

        S_ACK: begin
          if (tick) begin
            phase <= phase + 2'd1;
            case (phase)
              2'd1: scl_o <= 1'b1;
              2'd2: begin
                ack_nack  <= sda_i;
                ack_valid <= 1'b1;
              end
              2'd3: begin
                // A NACK does not abort; the latched stop flag decides.
                scl_o <= 1'b0;
                sda_o <= 1'b0;
                if (stop) begin
                  state <= S_STOP;
                end else begin
                  tx_ready <= 1'b1;
                  state    <= S_HOLD;
                end
              end
              default: ;
            endcase
          end
        end

        S_STOP: begin
          if (tick) begin
            phase <= phase + 2'd1;
            case (phase)
              2'd1: scl_o <= 1'b1;
              2'd2: sda_o <= 1'b1;   // STOP: SDA rises while SCL is high
              2'd3: begin
                tx_ready <= 1'b1;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end
              default: ;
            endcase
          end
        end

        S_HOLD: begin
          // Bus stays owned with SCL stretched low until the next byte.
          q        <= '0;
          scl_o    <= 1'b0;
          sda_o    <= 1'b0;
          tx_ready <= 1'b1;
          if (accept) begin
            data     <= tx_data;
            stop     <= tx_stop;
            tx_ready <= 1'b0;
            sda_o    <= tx_data[7];  // no repeated START, straight to bit 7
            bit_idx  <= 3'd7;
            phase    <= '0;
            state    <= S_BIT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: self-checking bench for i2c_byte_master.
//
// Four instances run with DIV = 1..4 (lane l uses DIV = l+1). A behavioural
// model turns every accepted byte into the expected per-clock SCL/SDA
// waveform (quarters repeated DIV times) plus handshake/ACK outputs; one
// compare thread checks every lane on every falling edge and runs a
// loopback I2C decoder on the observed lines. Directed scenarios add
// hand-computed literal expectations; a randomized phase finishes the run.

module tb_i2c_byte_master;

  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0] tx_valid = '0;
  logic [NL-1:0] tx_stop  = '0;
  logic [NL-1:0] sda_i    = '0;
  logic [7:0]    tx_data [NL];
  wire  [NL-1:0] tx_ready, scl_o, sda_o, busy, ack_valid, ack_nack;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    i2c_byte_master #(.DIV(g + 1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_valid (tx_valid[g]),
      .tx_ready (tx_ready[g]),
      .tx_data  (tx_data[g]),
      .tx_stop  (tx_stop[g]),
      .sda_i    (sda_i[g]),
      .scl_o    (scl_o[g]),
      .sda_o    (sda_o[g]),
      .busy     (busy[g]),
      .ack_valid(ack_valid[g]),
      .ack_nack (ack_nack[g])
    );
  end

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic scl;
    logic sda;
    logic smp;   // last clock before the ACK sample edge
    logic ack;   // first clock with ack_valid high
  } wv_t;

  wv_t        wq      [NL][$];
  logic [7:0] sent_q  [NL][$];
  bit         m_rst   [NL];
  bit         m_hold  [NL];
  logic       m_nack  [NL];
  logic       m_ackv  [NL];
  int         m_starts[NL];
  int         m_stops [NL];

  // loopback decoder state
  logic       prev_scl[NL];
  logic       prev_sda[NL];
  int         dcnt    [NL];
  logic [7:0] dsh     [NL];
  logic [7:0] last_dec[NL];
  int         ndec    [NL];
  int         d_starts[NL];
  int         d_stops [NL];
  int         ack_cnt [NL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_q(input int l, input logic scl, input logic sda,
                        input logic smp_last, input logic ack_first);
    for (int i = 0; i <= l; i++) begin
      wv_t e;
      e = {scl, sda, smp_last && (i == l), ack_first && (i == 0)};
      wq[l].push_back(e);
    end
  endtask

  // Expected bus activity for one accepted byte, one entry per clock.
  task automatic model_accept(input int l, input logic [7:0] d, input logic st);
    if (!m_hold[l]) begin
      push_q(l, 1, 0, 0, 0);
      push_q(l, 1, 0, 0, 0);
      m_starts[l]++;
    end
    for (int b = 7; b >= 0; b--) begin
      push_q(l, 0, d[b], 0, 0);
      push_q(l, 0, d[b], 0, 0);
      push_q(l, 1, d[b], 0, 0);
      push_q(l, 1, d[b], 0, 0);
    end
    push_q(l, 0, 1, 0, 0);
    push_q(l, 0, 1, 0, 0);
    push_q(l, 1, 1, 1, 0);
    push_q(l, 1, 1, 0, 1);
    if (st) begin
      push_q(l, 0, 0, 0, 0);
      push_q(l, 0, 0, 0, 0);
      push_q(l, 1, 0, 0, 0);
      push_q(l, 1, 1, 0, 0);
      m_stops[l]++;
      m_hold[l] = 1'b0;
    end else begin
      m_hold[l] = 1'b1;
    end
    sent_q[l].push_back(d);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int l = 0; l < NL; l++) begin
          logic [5:0] exp, act;
          wv_t e;
          bit rst_cyc;
          rst_cyc = m_rst[l];
          // {scl, sda, tx_ready, busy, ack_valid, ack_nack}
          if (rst_cyc) begin
            exp = 6'b110000;
          end else if (wq[l].size() > 0) begin
            e = wq[l].pop_front();
            if (e.smp) m_ackv[l] = sda_i[l];
            if (e.ack) m_nack[l] = m_ackv[l];
            exp = {e.scl, e.sda, 1'b0, 1'b1, e.ack, m_nack[l]};
          end else if (m_hold[l]) begin
            exp = {4'b0011, 1'b0, m_nack[l]};
          end else begin
            exp = {4'b1110, 1'b0, m_nack[l]};
          end
          act = {scl_o[l], sda_o[l], tx_ready[l], busy[l], ack_valid[l], ack_nack[l]};
          check($sformatf("lane%0d outputs", l), {26'd0, act}, {26'd0, exp});
          if (ack_valid[l]) ack_cnt[l]++;

          // loopback decoder
          if (rst_cyc) begin
            dcnt[l] = 0;
            sent_q[l].delete();
          end else if (scl_o[l] && prev_scl[l] && (sda_o[l] !== prev_sda[l])) begin
            if (!sda_o[l]) begin
              d_starts[l]++;
              dcnt[l] = 0;
            end else begin
              d_stops[l]++;
            end
          end else if (scl_o[l] && !prev_scl[l]) begin
            if (dcnt[l] < 8) begin
              dsh[l] = {dsh[l][6:0], sda_o[l]};
              dcnt[l]++;
              if (dcnt[l] == 8) begin
                ndec[l]++;
                last_dec[l] = dsh[l];
                if (sent_q[l].size() == 0)
                  check($sformatf("lane%0d unexpected byte", l), {24'd0, dsh[l]}, 32'h100);
                else
                  check($sformatf("lane%0d decoded byte", l), {24'd0, dsh[l]},
                        {24'd0, sent_q[l].pop_front()});
              end
            end else begin
              dcnt[l] = 0;
            end
          end
          prev_scl[l] = scl_o[l];
          prev_sda[l] = sda_o[l];

          // advance the model with the inputs the next edge will sample
          if (!rst_n) begin
            wq[l].delete();
            m_rst[l]  = 1'b1;
            m_hold[l] = 1'b0;
            m_nack[l] = 1'b0;
          end else begin
            m_rst[l] = 1'b0;
            if (exp[3] && tx_valid[l]) model_accept(l, tx_data[l], tx_stop[l]);
          end
        end
      end
    end
  endtask

  // ------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int l, input int budget);
    for (int i = 0; i < budget && !tx_ready[l]; i++) step();
    check($sformatf("lane%0d ready within budget", l), {31'd0, tx_ready[l]}, 32'd1);
  endtask

  // Offer one byte, release tx_valid after the accept edge, and count edges
  // from the accept edge until tx_ready is seen high again.
  task automatic send(input int l, input logic [7:0] d, input logic st, output int lat);
    tx_data[l]  = d;
    tx_stop[l]  = st;
    tx_valid[l] = 1'b1;
    wait_ready(l, 400);
    step();
    tx_valid[l] = 1'b0;
    lat = 0;
    while (!tx_ready[l] && lat < 1000) begin
      step();
      lat++;
    end
  endtask

  int lat, lat2, n, lo, hi, acks_before, ndec_before;

  initial begin
    for (int l = 0; l < NL; l++) begin
      tx_data[l]  = '0;
      m_rst[l]    = 1'b1;
      m_hold[l]   = 1'b0;
      m_nack[l]   = 1'b0;
      m_ackv[l]   = 1'b0;
      m_starts[l] = 0;
      m_stops[l]  = 0;
      prev_scl[l] = 1'b1;
      prev_sda[l] = 1'b1;
      dcnt[l]     = 0;
      dsh[l]      = '0;
      last_dec[l] = '0;
      ndec[l]     = 0;
      d_starts[l] = 0;
      d_stops[l]  = 0;
      ack_cnt[l]  = 0;
    end

    fork
      compare_loop();
      begin
        #800000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      end
      begin
        // reset: outputs are checked against reset values while held
        repeat (3) step();
        cmp_en = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("tx_ready after reset release", {28'd0, tx_ready}, 32'hF);

        // DIV=1, 0xA5 with STOP, target ACKs
        sda_i[0] = 1'b0;
        send(0, 8'hA5, 1'b1, lat);
        check("div1 latency idle+stop", lat, 42);
        check("div1 decoded 0xA5", {24'd0, last_dec[0]}, 32'hA5);
        check("div1 ack_nack", {31'd0, ack_nack[0]}, 0);
        check("div1 ack pulses", ack_cnt[0], 1);
        check("div1 stop count", d_stops[0], 1);

        // DIV=3, 0x3C with STOP, target NACKs; measure SCL halves
        sda_i[2]   = 1'b1;
        tx_data[2] = 8'h3C;
        tx_stop[2] = 1'b1;
        tx_valid[2] = 1'b1;
        wait_ready(2, 400);
        step();
        tx_valid[2] = 1'b0;
        n = 0;
        while (scl_o[2] && n < 100) begin step(); n++; end
        lo = 0;
        while (!scl_o[2] && lo < 100) begin step(); lo++; end
        hi = 0;
        while (scl_o[2] && hi < 100) begin step(); hi++; end
        check("div3 scl low half", lo, 6);
        check("div3 scl high half", hi, 6);
        wait_ready(2, 400);
        check("div3 ack_nack", {31'd0, ack_nack[2]}, 1);
        check("div3 stop after nack", d_stops[2], 1);
        check("div3 decoded 0x3C", {24'd0, last_dec[2]}, 32'h3C);

        // DIV=2, 0x12 (no STOP) then 0x34 (STOP) with tx_valid held high
        tx_data[1]  = 8'h12;
        tx_stop[1]  = 1'b0;
        tx_valid[1] = 1'b1;
        wait_ready(1, 400);
        step();
        tx_data[1] = 8'h34;
        tx_stop[1] = 1'b1;
        lat = 0;
        while (!tx_ready[1] && lat < 1000) begin step(); lat++; end
        check("div2 latency idle->hold", lat, 76);
        check("div2 hold lines", {30'd0, scl_o[1], sda_o[1]}, 0);
        step();
        tx_valid[1] = 1'b0;
        lat2 = 0;
        while (!tx_ready[1] && lat2 < 1000) begin step(); lat2++; end
        check("div2 latency hold+stop", lat2, 80);
        check("div2 start count", d_starts[1], 1);
        check("div2 stop count", d_stops[1], 1);
        check("div2 ack pulses", ack_cnt[1], 2);
        check("div2 bytes decoded", ndec[1], 2);
        check("div2 last byte", {24'd0, last_dec[1]}, 32'h34);

        // DIV=4: two bytes ending in HOLD, then reset during bit 4 of a third
        send(3, 8'h5A, 1'b0, lat);
        check("div4 latency idle->hold", lat, 152);
        send(3, 8'hC3, 1'b0, lat);
        check("div4 latency hold->hold", lat, 144);
        acks_before = ack_cnt[3];
        tx_data[3]  = 8'h0F;
        tx_stop[3]  = 1'b0;
        tx_valid[3] = 1'b1;
        step();
        tx_valid[3] = 1'b0;
        repeat (56) step();
        rst_n = 1'b0;
        step();
        check("reset lines released", {29'd0, scl_o[3], sda_o[3], busy[3]}, 32'b110);
        check("reset tx_ready low", {31'd0, tx_ready[3]}, 0);
        rst_n = 1'b1;
        step();
        check("ready after mid reset", {31'd0, tx_ready[3]}, 1);
        repeat (300) step();
        check("no ack after reset", ack_cnt[3], acks_before);
        check("bus idle after reset", {30'd0, scl_o[3], sda_o[3]}, 32'b11);

        // tx_valid pulse while busy is ignored
        ndec_before = ndec[0];
        tx_data[0]  = 8'h96;
        tx_stop[0]  = 1'b1;
        tx_valid[0] = 1'b1;
        wait_ready(0, 400);
        step();
        tx_valid[0] = 1'b0;
        repeat (5) step();
        tx_data[0]  = 8'hFF;
        tx_stop[0]  = 1'b0;
        tx_valid[0] = 1'b1;
        step();
        tx_valid[0] = 1'b0;
        wait_ready(0, 400);
        repeat (60) step();
        check("ignored pulse bus released", {29'd0, scl_o[0], sda_o[0], busy[0]}, 32'b110);
        check("ignored pulse byte count", ndec[0] - ndec_before, 1);
        check("ignored pulse byte", {24'd0, last_dec[0]}, 32'h96);

        // randomized traffic on every lane
        for (int l = 0; l < NL; l++) begin
          for (int k = 0; k < 1500; k++) begin
            tx_valid[l] = ($urandom_range(0, 3) == 0);
            tx_data[l]  = 8'($urandom);
            tx_stop[l]  = 1'($urandom);
            sda_i[l]    = 1'($urandom);
            step();
          end
          tx_valid[l] = 1'b0;
          wait_ready(l, 400);
          repeat (4) step();
        end

        for (int l = 0; l < NL; l++) begin
          check($sformatf("lane%0d undelivered bytes", l), sent_q[l].size(), 0);
          check($sformatf("lane%0d start count", l), d_starts[l], m_starts[l]);
          check($sformatf("lane%0d stop count", l), d_stops[l], m_stops[l]);
        end
      end
    join_any

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
